// File: rtl/enc_frame_pkg.sv
// Shared types and helpers for the encoder frame scheduler.
package enc_frame_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned MAX_CH = 8;
  localparam int unsigned IDX_W  = $clog2(MAX_CH);
  localparam int unsigned POS_W  = DATA_W * MAX_CH;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    TS,
    POS
  } state_t;

  typedef struct packed {
    logic [7:0] magic;
    logic [7:0] id;
    logic [7:0] seq;
    logic [7:0] mask;
  } hdr_t;

  function automatic logic [DATA_W-1:0] build_hdr(input logic [7:0] id,
                                                  input logic [7:0] seq_num,
                                                  input logic [7:0] mask);
    hdr_t h;
    h.magic = HDR_MAGIC;
    h.id    = id;
    h.seq   = seq_num;
    h.mask  = mask;
    return h;
  endfunction

  // Index of the highest enabled channel; marks the word that carries tlast.
  function automatic logic [IDX_W-1:0] hi_idx(input logic [MAX_CH-1:0] mask);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(MAX_CH); i++) begin
      if (mask[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/enc_next_ch.sv
// Combinational priority finder: lowest enabled channel above cur (or from 0).
module enc_next_ch
  import enc_frame_pkg::*;
(
  input  logic [MAX_CH-1:0] mask,
  input  logic [IDX_W-1:0]  cur,
  input  logic              from_start,
  output logic [IDX_W-1:0]  nxt_c,
  output logic              none_c
);

  // Scan downward so the lowest qualifying index wins.
  always_comb begin
    nxt_c  = '0;
    none_c = 1'b1;
    for (int i = int'(MAX_CH) - 1; i >= 0; i--) begin
      if (mask[i] && (from_start || (IDX_W'(i) > cur))) begin
        nxt_c  = IDX_W'(i);
        none_c = 1'b0;
      end
    end
  end

endmodule

// File: rtl/enc_frame_sched.sv
// Snapshots timestamp and encoder positions on each tick and streams them
// as one AXI4-Stream frame: header, timestamp, enabled positions.
module enc_frame_sched
  import enc_frame_pkg::*;
#(
  parameter logic [7:0]  ID   = 8'h00,
  parameter int unsigned N_CH = 2
) (
  input  logic                     dev_clk,
  input  logic                     dev_rst,
  input  logic                     tick,
  input  logic [DATA_W-1:0]        time_stamp,
  input  logic [DATA_W*N_CH-1:0]   ch_pos,
  input  logic [N_CH-1:0]          ch_en,
  output logic [DATA_W-1:0]        m_axis_tdata,
  output logic                     m_axis_tvalid,
  output logic                     m_axis_tlast,
  input  logic                     m_axis_tready,
  output logic                     busy,
  output logic [15:0]              overrun_cnt,
  output logic [7:0]               seq
);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   tdata_d;
  logic                tvalid_d, tlast_d;
  logic [7:0]          seq_d;
  logic [15:0]         ovr_d;
  logic                accept;
  logic                xfer;

  logic [DATA_W-1:0]   ts_q;
  logic [DATA_W-1:0]   pos_q [MAX_CH];
  logic [MAX_CH-1:0]   en_q;
  logic [IDX_W-1:0]    last_q;
  logic [POS_W-1:0]    pos_full;
  logic [MAX_CH-1:0]   en_full;

  logic [IDX_W-1:0]    nxt_idx;
  logic                nxt_none;

  assign pos_full = POS_W'(ch_pos);
  assign en_full  = MAX_CH'(ch_en);
  assign xfer     = m_axis_tvalid && m_axis_tready;

  enc_next_ch u_next_ch (
    .mask       (en_q),
    .cur        (idx_q),
    .from_start (state_q == TS),
    .nxt_c      (nxt_idx),
    .none_c     (nxt_none)
  );

  // Next-state and next-output logic; everything holds while stalled.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tdata_d  = m_axis_tdata;
    tvalid_d = m_axis_tvalid;
    tlast_d  = m_axis_tlast;
    seq_d    = seq;
    ovr_d    = overrun_cnt;
    accept   = 1'b0;

    if (tick && (state_q != IDLE) && (overrun_cnt != 16'hFFFF)) begin
      ovr_d = overrun_cnt + 16'd1;
    end

    case (state_q)
      IDLE: begin
        if (tick) begin
          accept   = 1'b1;
          state_d  = HDR;
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
          tdata_d  = build_hdr(ID, seq, 8'(ch_en));
        end
      end
      HDR: begin
        if (xfer) begin
          state_d = TS;
          tdata_d = ts_q;
          tlast_d = (en_q == '0);
        end
      end
      TS, POS: begin
        if (xfer) begin
          if (nxt_none) begin
            state_d  = IDLE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            seq_d    = seq + 8'd1;
          end else begin
            state_d = POS;
            idx_d   = nxt_idx;
            tdata_d = pos_q[nxt_idx];
            tlast_d = (nxt_idx == last_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge dev_clk) begin
    if (dev_rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      busy          <= 1'b0;
      overrun_cnt   <= '0;
      seq           <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      m_axis_tdata  <= tdata_d;
      m_axis_tvalid <= tvalid_d;
      m_axis_tlast  <= tlast_d;
      busy          <= (state_d != IDLE);
      overrun_cnt   <= ovr_d;
      seq           <= seq_d;
    end
  end

  // Snapshot registers: frozen for the whole frame once a tick is accepted.
  always_ff @(posedge dev_clk) begin
    if (accept) begin
      ts_q   <= time_stamp;
      en_q   <= en_full;
      last_q <= hi_idx(en_full);
      for (int i = 0; i < int'(MAX_CH); i++) begin
        pos_q[i] <= pos_full[DATA_W*i +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_enc_frame_sched.sv
// Scoreboard bench for enc_frame_sched: expected words queued at tick time.
module tb_enc_frame_sched;

  localparam int unsigned N_CH = 2;
  localparam logic [7:0]  ID   = 8'h5A;

  logic              dev_clk = 1'b0;
  logic              dev_rst;
  logic              tick;
  logic [31:0]       time_stamp;
  logic [32*N_CH-1:0] ch_pos;
  logic [N_CH-1:0]   ch_en;
  logic [31:0]       m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic              m_axis_tready;
  logic              busy;
  logic [15:0]       overrun_cnt;
  logic [7:0]        seq;

  enc_frame_sched #(.ID(ID), .N_CH(N_CH)) dut (
    .dev_clk       (dev_clk),
    .dev_rst       (dev_rst),
    .tick          (tick),
    .time_stamp    (time_stamp),
    .ch_pos        (ch_pos),
    .ch_en         (ch_en),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .overrun_cnt   (overrun_cnt),
    .seq           (seq)
  );

  always #10 dev_clk = ~dev_clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          mode = 0;
  int          pat = 0;
  int          hdr_due = -1;
  int          last_hs = -10;
  logic        gapless = 1'b0;
  logic [7:0]  seq_m = 8'd0;
  logic [15:0] ovr_m = 16'd0;
  // bit 33: header word, bit 32: tlast, [31:0]: tdata
  logic [33:0] exp_q [$];

  logic [33:0] w;
  logic        prev_stall = 1'b0;
  logic        prev_last = 1'b0;
  logic [31:0] prev_data = 32'd0;

  task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge dev_clk) cyc <= cyc + 1;

  // Output monitor: stability under stall, scoreboard pop on handshake.
  always @(negedge dev_clk) begin
    if (prev_stall) begin
      check("stall_valid", 33'(m_axis_tvalid), 33'd1);
      check("stall_data", 33'(m_axis_tdata), 33'(prev_data));
      check("stall_last", 33'(m_axis_tlast), 33'(prev_last));
    end
    prev_stall = m_axis_tvalid && !m_axis_tready && !dev_rst;
    prev_data  = m_axis_tdata;
    prev_last  = m_axis_tlast;
    if (m_axis_tvalid && m_axis_tready && !dev_rst) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 33'd1, 33'd0);
      end else begin
        w = exp_q.pop_front();
        check("word", {m_axis_tlast, m_axis_tdata}, w[32:0]);
        if (gapless) begin
          if (w[33]) check("hdr_latency", 33'(cyc), 33'(hdr_due));
          else       check("no_bubble", 33'(cyc), 33'(last_hs + 1));
        end
        last_hs = cyc;
      end
    end
  end

  task automatic step();
    @(posedge dev_clk);
    #1;
    time_stamp = time_stamp + 32'd1;
    case (mode)
      0: m_axis_tready = 1'b1;
      1: begin
        m_axis_tready = (pat % 3 == 0);
        pat++;
        ch_pos = {$urandom(), $urandom()};
        ch_en  = 2'($urandom());
      end
      2: m_axis_tready = 1'b0;
      default: m_axis_tready = 1'($urandom() % 2);
    endcase
  endtask

  task automatic send_frame(input logic [1:0] en, input logic [31:0] p0, input logic [31:0] p1);
    ch_en  = en;
    ch_pos = {p1, p0};
    tick   = 1'b1;
    exp_q.push_back({2'b10, 8'hA5, ID, seq_m, 6'd0, en});
    exp_q.push_back({1'b0, (en == 2'b00), time_stamp});
    if (en[0]) exp_q.push_back({1'b0, !en[1], p0});
    if (en[1]) exp_q.push_back({2'b01, p1});
    hdr_due = cyc + 1;
    seq_m   = seq_m + 8'd1;
    step();
    tick = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && (exp_q.size() != 0 || busy); i++) step();
    check("drain", 33'(exp_q.size()), 33'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    dev_rst = 1'b1; tick = 1'b0; m_axis_tready = 1'b0;
    ch_en = '0; ch_pos = '0; time_stamp = 32'd0;
    repeat (3) step();
    check("rst_tvalid", 33'(m_axis_tvalid), 33'd0);
    check("rst_tlast", 33'(m_axis_tlast), 33'd0);
    check("rst_tdata", 33'(m_axis_tdata), 33'd0);
    check("rst_busy", 33'(busy), 33'd0);
    check("rst_ovr", 33'(overrun_cnt), 33'd0);
    check("rst_seq", 33'(seq), 33'd0);
    dev_rst = 1'b0;
    mode = 0;
    step();

    // Basic frame, both channels, no backpressure.
    gapless = 1'b1;
    time_stamp = 32'h10;
    send_frame(2'b11, 32'h100, 32'hFFFFFF00);
    wait_idle();
    check("seq_after_1", 33'(seq), 33'(seq_m));

    // Sparse and empty masks.
    send_frame(2'b10, 32'h1111, 32'h2222);
    wait_idle();
    send_frame(2'b00, 32'h3333, 32'h4444);
    wait_idle();
    send_frame(2'b01, 32'hDEADBEEF, 32'h5555);
    wait_idle();

    // Stall pattern with inputs changing mid-frame, then random tready.
    gapless = 1'b0;
    mode = 1;
    for (int i = 0; i < 6; i++) begin
      send_frame(2'(i % 4), $urandom(), $urandom());
      wait_idle();
    end
    mode = 3;
    for (int i = 0; i < 8; i++) begin
      send_frame(2'($urandom()), $urandom(), $urandom());
      wait_idle();
    end
    mode = 0;
    check("seq_after_rand", 33'(seq), 33'(seq_m));

    // Dropped ticks while stalled.
    mode = 2;
    send_frame(2'b11, 32'hA, 32'hB);
    for (int i = 0; i < 3; i++) begin
      step();
      tick = 1'b1;
      step();
      tick = 1'b0;
      ovr_m = ovr_m + 16'd1;
    end
    check("ovr_3", 33'(overrun_cnt), 33'(ovr_m));
    check("seq_stalled", 33'(seq), 33'(seq_m - 8'd1));
    check("busy_stalled", 33'(busy), 33'd1);
    mode = 0;
    wait_idle();
    check("seq_after_ovr", 33'(seq), 33'(seq_m));

    // Tick on the final-handshake cycle is dropped too.
    send_frame(2'b00, 32'h0, 32'h0);
    step();
    tick = 1'b1;
    step();
    tick = 1'b0;
    ovr_m = ovr_m + 16'd1;
    check("ovr_final_hs", 33'(overrun_cnt), 33'(ovr_m));
    check("busy_final_hs", 33'(busy), 33'd0);
    wait_idle();

    // Saturation of the overrun counter.
    mode = 2;
    send_frame(2'b01, 32'h77, 32'h88);
    tick = 1'b1;
    repeat (65540) step();
    tick = 1'b0;
    check("ovr_sat", 33'(overrun_cnt), 33'h0FFFF);
    mode = 0;
    wait_idle();

    // Reset during the POS word.
    send_frame(2'b11, 32'hCAFE0000, 32'hCAFE0001);
    step();
    step();
    dev_rst = 1'b1;
    mode = 2;
    m_axis_tready = 1'b0;
    step();
    check("mid_rst_tvalid", 33'(m_axis_tvalid), 33'd0);
    check("mid_rst_tlast", 33'(m_axis_tlast), 33'd0);
    check("mid_rst_seq", 33'(seq), 33'd0);
    check("mid_rst_ovr", 33'(overrun_cnt), 33'd0);
    check("mid_rst_busy", 33'(busy), 33'd0);
    exp_q.delete();
    seq_m = 8'd0;
    ovr_m = 16'd0;
    dev_rst = 1'b0;
    mode = 0;
    step();
    gapless = 1'b1;
    send_frame(2'b01, 32'h12345678, 32'h9);
    wait_idle();
    check("seq_post_rst", 33'(seq), 33'd1);

    // Sequence wrap over 256 frames.
    for (int i = 0; i < 256; i++) begin
      send_frame(2'(i), 32'(i), ~32'(i));
      wait_idle();
    end
    check("seq_wrap", 33'(seq), 33'(seq_m));
    check("ovr_final", 33'(overrun_cnt), 33'(ovr_m));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
